dequantize: RTL and testbench

DEQUANTIZE -- requirements
Module: dequantize

---
 rtl/dequantize.sv | 106 ++++++++++
 tb/tb_dequantize.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dequantize.sv
// Reconstructs a left-aligned 18-bit sample from a right-aligned Nquant-bit two's-complement code.
// One bit is shifted per cycle, then an optional half-LSB midpoint offset is added.
module dequantize #(
    parameter int unsigned MIDPOINT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  Nquant,
    input  logic [17:0] datain,
    input  logic        endatain,
    output logic [17:0] dataout,
    output logic        dataready,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StShift, StAdjust} state_e;

    state_e      state_q, state_d;
    logic [17:0] sr_q, sr_d;
    logic [4:0]  shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [17:0] dataout_q, dataout_d;
    logic        dataready_q, dataready_d;

    logic [4:0]  nq;
    logic [4:0]  shift_in;
    logic [17:0] low_mask;
    logic [17:0] code_ext;
    logic [17:0] offset;

    // Clamp the code width and sign-extend the selected low bits of datain.
    always_comb begin
        nq = Nquant;
        if (Nquant == 5'd0) begin
            nq = 5'd1;
        end else if (Nquant > 5'd18) begin
            nq = 5'd18;
        end
        shift_in = 5'd18 - nq;
        low_mask = 18'h3FFFF >> shift_in;
        code_ext = datain[nq - 5'd1] ? (datain | ~low_mask) : (datain & low_mask);
    end

    // Low shift bits of sr_q are zero after shifting, so this add cannot carry out.
    always_comb begin
        offset = 18'd0;
        if ((MIDPOINT != 0) && (shift_q != 5'd0)) begin
            offset = 18'd1 << (shift_q - 5'd1);
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        dataout_d   = dataout_q;
        dataready_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (endatain) begin
                    sr_d    = code_ext;
                    shift_d = shift_in;
                    cnt_d   = 5'd0;
                    state_d = (shift_in != 5'd0) ? StShift : StAdjust;
                end
            end
            StShift: begin
                sr_d  = {sr_q[16:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q + 5'd1 == shift_q) begin
                    state_d = StAdjust;
                end
            end
            StAdjust: begin
                dataout_d   = sr_q + offset;
                dataready_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sr_q        <= 18'd0;
            shift_q     <= 5'd0;
            cnt_q       <= 5'd0;
            dataout_q   <= 18'd0;
            dataready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            dataout_q   <= dataout_d;
            dataready_q <= dataready_d;
        end
    end

    assign dataout   = dataout_q;
    assign dataready = dataready_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dequantize.sv
// Self-checking bench for dequantize: table-driven vectors on MIDPOINT=1 and MIDPOINT=0 instances,
// with a scoreboard of expected samples and completion cycles.
module tb_dequantize;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  Nquant = 5'd0;
    logic [17:0] datain = 18'd0;
    logic        endatain = 1'b0;
    logic [17:0] dataout, dataout_p;
    logic        dataready, dataready_p, busy, busy_p;

    dequantize #(.MIDPOINT(1)) dut (
        .clock(clock), .reset(reset), .Nquant(Nquant), .datain(datain), .endatain(endatain),
        .dataout(dataout), .dataready(dataready), .busy(busy)
    );

    dequantize #(.MIDPOINT(0)) dut_p (
        .clock(clock), .reset(reset), .Nquant(Nquant), .datain(datain), .endatain(endatain),
        .dataout(dataout_p), .dataready(dataready_p), .busy(busy_p)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [17:0] e1;
        logic [17:0] e0;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic [4:0]  nq;
        logic [17:0] din;
        logic [17:0] e1;
        logic [17:0] e0;
        int unsigned lat;
    } vec_t;

    exp_t        sb[$];
    exp_t        got;
    vec_t        vecs[9];
    int          errors = 0;
    int          checks = 0;
    logic [17:0] last1 = 18'd0;
    logic [17:0] last0 = 18'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every dataready pops one expectation; between pulses dataout must hold.
    always @(negedge clock) begin
        if (!reset) begin
            if (dataready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_dataready: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    got = sb.pop_front();
                    chk("dataout_mid1", {14'd0, dataout}, {14'd0, got.e1});
                    chk("dataout_mid0", {14'd0, dataout_p}, {14'd0, got.e0});
                    chk("latency_cycle", cyc, got.due);
                    chk("dataready_mid0", {31'd0, dataready_p}, 32'd1);
                    last1 = got.e1;
                    last0 = got.e0;
                end
            end else begin
                chk("hold_mid1", {14'd0, dataout}, {14'd0, last1});
                chk("hold_mid0", {14'd0, dataout_p}, {14'd0, last0});
            end
        end
    end

    task automatic start_vec(input logic [4:0] nq, input logic [17:0] din, input logic [17:0] e1,
                             input logic [17:0] e0, input int unsigned lat);
        exp_t e;
        for (int k = 0; k < 64 && busy; k++) @(negedge clock);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
            return;
        end
        Nquant   = nq;
        datain   = din;
        endatain = 1'b1;
        e.e1  = e1;
        e.e0  = e0;
        e.due = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clock);
        // Scramble inputs and poke endatain while busy; none of it may matter.
        endatain = 1'b0;
        Nquant   = 5'($urandom);
        datain   = 18'($urandom);
        for (int k = 0; k < 64 && busy; k++) begin
            endatain = 1'($urandom);
            @(negedge clock);
        end
        endatain = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        exp_t e;

        vecs[0] = '{5'd8,  18'h00081, 18'h20600, 18'h20400, 11};
        vecs[1] = '{5'd18, 18'h2ABCD, 18'h2ABCD, 18'h2ABCD, 1};
        vecs[2] = '{5'd4,  18'h3FFF7, 18'h1E000, 18'h1C000, 15};
        vecs[3] = '{5'd0,  18'h00001, 18'h30000, 18'h20000, 18};
        vecs[4] = '{5'd25, 18'h2ABCD, 18'h2ABCD, 18'h2ABCD, 1};
        vecs[5] = '{5'd1,  18'h00000, 18'h10000, 18'h00000, 18};
        vecs[6] = '{5'd16, 18'h3FFFF, 18'h3FFFE, 18'h3FFFC, 3};
        vecs[7] = '{5'd12, 18'h3F7FF, 18'h1FFE0, 18'h1FFC0, 7};
        vecs[8] = '{5'd12, 18'h00800, 18'h20020, 18'h20000, 7};

        #1;
        chk("reset_dataout", {14'd0, dataout}, 32'd0);
        chk("reset_dataready", {31'd0, dataready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_vec(vecs[i].nq, vecs[i].din, vecs[i].e1, vecs[i].e0, vecs[i].lat);
        end

        // endatain held high with Nquant=16: accepts every 4 cycles.
        for (int k = 0; k < 64 && busy; k++) @(negedge clock);
        c = cyc;
        Nquant   = 5'd16;
        datain   = 18'h01234;
        endatain = 1'b1;
        for (int j = 0; j < 3; j++) begin
            e.e1  = 18'h048D2;
            e.e0  = 18'h048D0;
            e.due = c + 1 + 4 * j + 3;
            sb.push_back(e);
        end
        repeat (9) @(negedge clock);
        endatain = 1'b0;
        for (int k = 0; k < 64 && busy; k++) @(negedge clock);

        // Reset in the middle of a shift: outputs clear before the next edge, no result follows.
        for (int k = 0; k < 64 && sb.size() > 0; k++) @(negedge clock);
        Nquant   = 5'd8;
        datain   = 18'h00081;
        endatain = 1'b1;
        @(negedge clock);
        endatain = 1'b0;
        repeat (3) @(negedge clock);
        chk("busy_mid_shift", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_dataout", {14'd0, dataout}, 32'd0);
        chk("async_dataout_mid0", {14'd0, dataout_p}, 32'd0);
        chk("async_dataready", {31'd0, dataready}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        last1 = 18'd0;
        last0 = 18'd0;
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        start_vec(5'd8, 18'h00081, 18'h20600, 18'h20400, 11);

        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
